la_clkdiv: RTL and testbench

Programmable integer clock divider producing a glitch-free, registered divided clock from a single source clock.
- Sits directly upstream of the library's non-inverting clock buffer cell, which distributes clkout to the divided domain.
- Divisor changes and enable/disable take effect only at period boundaries, so clkout never shows a runt pulse.
- Also supplies a one-cycle strobe aligned to each clkout rising edge, for logic that stays in the source clock domain.

---
 rtl/la_clkdiv.sv | 100 ++++++++++
 tb/tb_la_clkdiv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/la_clkdiv.sv
// Programmable integer clock divider with a registered, glitch-free clkout.
// Divisor and enable changes are only honoured at period boundaries.
module la_clkdiv #(
  parameter int    DW   = 8,
  parameter string PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] div,
  output logic          clkout,
  output logic          rise,
  output logic          active,
  output logic [DW-1:0] divact
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // PROP only steers technology mapping; nothing is generated from it here.
  if (PROP == "") begin : g_prop_empty
  end

  state_t        r_state;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_divact;
  logic          r_clkout;
  logic          r_rise;

  logic          w_start;
  logic          w_last;
  logic [DW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_half;

  assign w_start   = en && (div >= DW'(2));
  assign w_last    = (r_cnt == (r_divact - DW'(1)));
  assign w_cnt_nxt = r_cnt + DW'(1);
  assign w_half    = r_divact >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_divact <= '0;
      r_clkout <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_RUN;
            r_divact <= div;
            r_cnt    <= '0;
            r_clkout <= 1'b1;
            r_rise   <= 1'b1;
          end else begin
            r_cnt    <= '0;
            r_divact <= '0;
            r_clkout <= 1'b0;
            r_rise   <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_last) begin
            r_cnt    <= w_cnt_nxt;
            r_clkout <= (w_cnt_nxt < w_half);
            r_rise   <= 1'b0;
          end else if (w_start) begin
            // Back-to-back period: the divisor present at this edge takes over.
            r_divact <= div;
            r_cnt    <= '0;
            r_clkout <= 1'b1;
            r_rise   <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            r_divact <= '0;
            r_cnt    <= '0;
            r_clkout <= 1'b0;
            r_rise   <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_divact <= '0;
          r_clkout <= 1'b0;
          r_rise   <= 1'b0;
        end
      endcase
    end
  end

  assign clkout = r_clkout;
  assign rise   = r_rise;
  assign active = (r_state == S_RUN);
  assign divact = r_divact;

endmodule

// File: tb/tb_la_clkdiv.sv
// Bench for la_clkdiv: fixed vector table, reset corner case and randomized
// traffic compared against a period-position reference model.
module tb_la_clkdiv;

  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          en;
  logic [DW-1:0] div;
  logic          clkout;
  logic          rise;
  logic          active;
  logic [DW-1:0] divact;

  int n_chk;
  int n_err;

  // Reference: m_n is the ratio of the period in progress (0 = idle),
  // m_pos is how many clk cycles of that period have already elapsed.
  int m_n;
  int m_pos;

  la_clkdiv #(.DW(DW), .PROP("DEFAULT")) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .div    (div),
    .clkout (clkout),
    .rise   (rise),
    .active (active),
    .divact (divact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         en;
    logic [7:0] div;
    bit         clkout;
    bit         rise;
    bit         active;
    logic [7:0] divact;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n   = 0;
    m_pos = 0;
  endtask

  task automatic model_edge(input bit e, input int d);
    if (m_n == 0 || m_pos == m_n - 1) begin
      if (e && d >= 2) begin
        m_n   = d;
        m_pos = 0;
      end else begin
        m_n   = 0;
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic chk_model(input string tag);
    int hi;
    hi = m_n / 2;
    chk({tag, ".clkout"}, int'(clkout), (m_n != 0 && m_pos < hi) ? 1 : 0);
    chk({tag, ".rise"},   int'(rise),   (m_n != 0 && m_pos == 0) ? 1 : 0);
    chk({tag, ".active"}, int'(active), (m_n != 0) ? 1 : 0);
    chk({tag, ".divact"}, int'(divact), m_n);
  endtask

  // Apply inputs, take one clk edge, then check 1 time unit later.
  task automatic cyc(input bit e, input logic [7:0] d, input string tag);
    en  = e;
    div = d;
    @(posedge clk);
    model_edge(e, int'(d));
    #1;
    chk_model(tag);
  endtask

  vec_t vt[19];
  int   hi_cnt;

  initial begin
    n_chk = 0;
    n_err = 0;
    en    = 1'b0;
    div   = '0;
    reset = 1'b1;
    model_reset();
    #2;
    chk("rst.clkout", int'(clkout), 0);
    chk("rst.rise",   int'(rise),   0);
    chk("rst.active", int'(active), 0);
    chk("rst.divact", int'(divact), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // {en, div} applied before the edge -> outputs after the edge
    vt[0]  = '{1, 8'd4, 1, 1, 1, 8'd4};
    vt[1]  = '{1, 8'd4, 1, 0, 1, 8'd4};
    vt[2]  = '{1, 8'd6, 0, 0, 1, 8'd4};
    vt[3]  = '{1, 8'd6, 0, 0, 1, 8'd4};
    vt[4]  = '{1, 8'd6, 1, 1, 1, 8'd6};
    vt[5]  = '{1, 8'd4, 1, 0, 1, 8'd6};
    vt[6]  = '{1, 8'd4, 1, 0, 1, 8'd6};
    vt[7]  = '{0, 8'd4, 0, 0, 1, 8'd6};
    vt[8]  = '{0, 8'd4, 0, 0, 1, 8'd6};
    vt[9]  = '{0, 8'd4, 0, 0, 1, 8'd6};
    vt[10] = '{0, 8'd4, 0, 0, 0, 8'd0};
    vt[11] = '{1, 8'd0, 0, 0, 0, 8'd0};
    vt[12] = '{1, 8'd1, 0, 0, 0, 8'd0};
    vt[13] = '{1, 8'd2, 1, 1, 1, 8'd2};
    vt[14] = '{1, 8'd2, 0, 0, 1, 8'd2};
    vt[15] = '{1, 8'd3, 1, 1, 1, 8'd3};
    vt[16] = '{0, 8'd3, 0, 0, 1, 8'd3};
    vt[17] = '{0, 8'd3, 0, 0, 1, 8'd3};
    vt[18] = '{0, 8'd3, 0, 0, 0, 8'd0};

    for (int i = 0; i < 19; i++) begin
      cyc(vt[i].en, vt[i].div, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_clkout", i), int'(clkout), int'(vt[i].clkout));
      chk($sformatf("vec%0d.t_rise", i),   int'(rise),   int'(vt[i].rise));
      chk($sformatf("vec%0d.t_active", i), int'(active), int'(vt[i].active));
      chk($sformatf("vec%0d.t_divact", i), int'(divact), int'(vt[i].divact));
    end

    // div=5 continuous: 1,1,0,0,0 twice
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'd5, "div5");
      chk("div5.pattern", int'(clkout), ((i % 5) < 2) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'd5, "div5stop");

    // Reset asserted mid high phase, away from any clk edge
    cyc(1'b1, 8'd8, "r8a");
    cyc(1'b1, 8'd8, "r8b");
    reset = 1'b1;
    #2;
    model_reset();
    chk("arst.clkout", int'(clkout), 0);
    chk("arst.rise",   int'(rise),   0);
    chk("arst.active", int'(active), 0);
    chk("arst.divact", int'(divact), 0);
    @(negedge clk);
    reset = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'd8, "r8run");
      if (clkout) hi_cnt++;
      chk("r8run.pattern", int'(clkout), (i < 4) ? 1 : 0);
    end
    chk("r8run.high_cycles", hi_cnt, 4);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'd8, "r8stop");

    // Randomized traffic, mostly small ratios plus occasional large ones
    for (int i = 0; i < 3000; i++) begin
      bit         e;
      logic [7:0] d;
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0)
        d = 8'($urandom_range(100, 255));
      else
        d = 8'($urandom_range(0, 9));
      cyc(e, d, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
